// File: rtl/alu_pkg.sv
// Shared types and constants for the bit-serial add/subtract datapath.
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder used as the serial ALU's bit slice.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub_unit.sv
// Bit-serial two's-complement add/subtract with N/Z/C/V flags and valid/ready on both sides.
// Optional build macro SERIAL_ADDSUB_SAT_EN: saturate the result on signed overflow.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready=1
// RUN   | one bit per cycle, LSB first, WIDTH cycles
// DONE  | result held with out_valid=1 until out_ready
module serial_addsub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags
);
  import alu_pkg::*;

  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-1:0] r_res;
  logic [3:0]       r_flags;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_cout;
  logic             w_v;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_final;
  logic [3:0]       w_flags;

  full_adder_bit u_fa (
    .a    (r_a[r_cnt]),
    .b    (r_b[r_cnt]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_res   = r_res;
  assign out_flags = r_flags;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == LAST);
  // Full result as it stands once the current bit lands on top of the shifted lower bits.
  assign w_sum    = {w_s, r_shift};
  assign w_v      = r_carry ^ w_cout;

`ifdef SERIAL_ADDSUB_SAT_EN
  assign w_final = !w_v          ? w_sum :
                   r_a[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                                   {1'b0, {(WIDTH-1){1'b1}}};
`else
  assign w_final = w_sum;
`endif

  always_comb begin
    w_flags         = '0;
    w_flags[FLAG_N] = w_final[WIDTH-1];
    w_flags[FLAG_Z] = (w_final == '0);
    w_flags[FLAG_C] = w_cout;
    w_flags[FLAG_V] = w_v;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = RUN;
      RUN:     if (w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_shift <= '0;
      r_res   <= '0;
      r_flags <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a     <= in_a;
            r_b     <= (in_sub == OP_ADD) ? in_b : ~in_b;
            r_carry <= (in_sub == OP_SUB);
            r_cnt   <= '0;
          end
        end
        RUN: begin
          r_shift <= w_sum[WIDTH-1:1];
          r_carry <= w_cout;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_res   <= w_final;
            r_flags <= w_flags;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Self-checking bench for serial_addsub_unit (WIDTH=4); honours SERIAL_ADDSUB_SAT_EN if defined.
module tb_serial_addsub_unit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_res;
  logic [3:0]   out_flags;

  int errors = 0;
  int checks = 0;

  serial_addsub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  // Reference: signed/unsigned integer arithmetic, returns {res, N, Z, C, V}.
  function automatic logic [W+3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub);
    int mask = (1 << W) - 1;
    int ua   = int'(a);
    int ub   = sub ? ((~int'(b)) & mask) : int'(b);
    int raw  = ua + ub + (sub ? 1 : 0);
    int sa   = int'($signed(a));
    int sb   = int'($signed(b));
    int tv   = sub ? (sa - sb) : (sa + sb);
    int maxp = (1 << (W - 1)) - 1;
    int minn = -(1 << (W - 1));
    logic v  = (tv > maxp) || (tv < minn);
    logic c  = ((raw >> W) & 1) != 0;
    logic [W-1:0] r = W'(raw);
`ifdef SERIAL_ADDSUB_SAT_EN
    if (v) r = (sa >= 0) ? W'(maxp) : W'(minn);
`endif
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  // Drives one operation from IDLE and collects the result; returns in IDLE.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        output logic [W-1:0] res, output logic [3:0] flags, output logic to);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_sub = sub; out_ready = 1'b0;
    while (!in_ready && n < 4 * W) begin @(negedge clk); n++; end
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n <= W + 2) begin @(negedge clk); n++; end
    to    = !out_valid;
    res   = out_res;
    flags = out_flags;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_res !== '0) begin errors++; $display("FAIL reset_res got=%b exp=0000", out_res); end
    checks++; if (out_flags !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", out_flags); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic [3:0]   flags;
  } vec_t;

  task automatic test_directed();
    vec_t v[7];
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         to;
    v[0] = '{4'b0011, 4'b0100, 1'b0, 4'b0111, 4'b0000};
    v[1] = '{4'b0101, 4'b0011, 1'b1, 4'b0010, 4'b0010};
    v[2] = '{4'b0011, 4'b0101, 1'b1, 4'b1110, 4'b1000};
    v[5] = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 4'b0110};
`ifdef SERIAL_ADDSUB_SAT_EN
    v[3] = '{4'b0111, 4'b0001, 1'b0, 4'b0111, 4'b0001};
    v[4] = '{4'b1000, 4'b0001, 1'b1, 4'b1000, 4'b1011};
    v[6] = '{4'b0000, 4'b1000, 1'b1, 4'b0111, 4'b0001};
`else
    v[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 4'b1001};
    v[4] = '{4'b1000, 4'b0001, 1'b1, 4'b0111, 4'b0011};
    v[6] = '{4'b0000, 4'b1000, 1'b1, 4'b1000, 4'b1001};
`endif
    for (int i = 0; i < 7; i++) begin
      run_op(v[i].a, v[i].b, v[i].sub, res, fl, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL dir%0d_timeout out_valid never rose", i); end
      checks++; if (res !== v[i].res) begin errors++; $display("FAIL dir%0d_res got=%b exp=%b", i, res, v[i].res); end
      checks++; if (fl !== v[i].flags) begin errors++; $display("FAIL dir%0d_flags got=%b exp=%b", i, fl, v[i].flags); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res;
    logic [3:0]   fl;
    logic         sub, to;
    logic [W+3:0] exp;
    for (int i = 0; i < 30; i++) begin
      a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
      exp = model(a, b, sub);
      run_op(a, b, sub, res, fl, to);
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout", i); end
      checks++;
      if ({res, fl} !== exp) begin
        errors++;
        $display("FAIL rnd%0d a=%b b=%b sub=%b got=%b/%b exp=%b/%b", i, a, b, sub, res, fl,
                 exp[W+3:4], exp[3:0]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] e1, e2;
    int n = 0;
    e1 = model(4'b0110, 4'b0011, 1'b0);
    e2 = model(4'b1001, 4'b0010, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'b0110; in_b = 4'b0011; in_sub = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    // Second operand pair held valid throughout RUN/DONE must not disturb the first.
    in_a = 4'b1001; in_b = 4'b0010; in_sub = 1'b1;
    while (!out_valid && n <= W + 2) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc%0d got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc%0d got=%b exp=0", i, in_ready); end
      checks++; if (out_res !== e1[W+3:4]) begin errors++; $display("FAIL bp_res cyc%0d got=%b exp=%b", i, out_res, e1[W+3:4]); end
      checks++; if (out_flags !== e1[3:0]) begin errors++; $display("FAIL bp_flags cyc%0d got=%b exp=%b", i, out_flags, e1[3:0]); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_post_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_post_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_res !== e1[W+3:4]) begin errors++; $display("FAIL bp_res_kept got=%b exp=%b", out_res, e1[W+3:4]); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_second_accept in_ready got=%b exp=0", in_ready); end
    n = 0;
    while (!out_valid && n <= W + 2) begin @(negedge clk); n++; end
    checks++;
    if ({out_res, out_flags} !== e2) begin
      errors++;
      $display("FAIL bp_second_result got=%b/%b exp=%b/%b", out_res, out_flags, e2[W+3:4], e2[3:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [W+3:0] q[$];
    logic [W+3:0] exp;
    int last = -1;
    int i = 0;
    int outs = 0;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
    while (i < 200 && (outs < 5 || q.size() != 0)) begin
      if (out_valid) begin
        exp = (q.size() != 0) ? q.pop_front() : 'x;
        outs++;
        checks++;
        if ({out_res, out_flags} !== exp) begin
          errors++;
          $display("FAIL b2b_result got=%b/%b exp=%b/%b", out_res, out_flags, exp[W+3:4], exp[3:0]);
        end
      end
      if (in_ready && in_valid) begin
        q.push_back(model(in_a, in_b, in_sub));
        if (last >= 0) begin
          checks++;
          if (i - last !== W + 2) begin errors++; $display("FAIL b2b_interval got=%0d exp=%0d", i - last, W + 2); end
        end
        last = i;
        if (q.size() >= 5) in_valid = 1'b0;
      end else if (i == last + 1) begin
        in_a = W'($urandom); in_b = W'($urandom); in_sub = 1'($urandom);
      end
      @(negedge clk);
      i++;
    end
    checks++; if (q.size() != 0 || outs < 5) begin errors++; $display("FAIL b2b_drain got=%0d outs exp=5", outs); end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] res;
    logic [3:0]   fl;
    logic         to;
    int seen = 0;
    run_op(4'b0011, 4'b0100, 1'b0, res, fl, to);
    @(negedge clk);
    in_valid = 1'b1; in_a = 4'b0010; in_b = 4'b0011; in_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstrun_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstrun_valid got=%b exp=0", out_valid); end
    checks++; if (out_res !== '0) begin errors++; $display("FAIL rstrun_res got=%b exp=0000", out_res); end
    checks++; if (out_flags !== 4'b0) begin errors++; $display("FAIL rstrun_flags got=%b exp=0000", out_flags); end
    out_ready = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    out_ready = 1'b0;
    checks++; if (seen != 0) begin errors++; $display("FAIL rstrun_no_result got=%0d valid cycles exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
